// File: rtl/note_sequencer_pkg.sv
// Note-code encodings, default tone constants and the fixed melody shared by the sound blocks.
// Pure constants and combinational helpers; no state.
package note_sequencer_pkg;

  localparam logic [1:0] NOTE_REST = 2'd0;
  localparam logic [1:0] NOTE_C    = 2'd1;
  localparam logic [1:0] NOTE_E    = 2'd2;
  localparam logic [1:0] NOTE_G    = 2'd3;

  // 12 MHz core: 100 ms duration tick, half-periods for C1/E1/G1
  localparam int unsigned DEF_TICK_CYCLES = 1200000;
  localparam int unsigned DEF_HALF_C      = 22933;
  localparam int unsigned DEF_HALF_E      = 18202;
  localparam int unsigned DEF_HALF_G      = 15306;

  typedef struct packed {
    logic [1:0] code;
    logic [3:0] dur;
  } melody_entry_t;

  function automatic melody_entry_t melody_entry(input logic [2:0] idx);
    melody_entry_t e;
    case (idx)
      3'd0:    e = '{code: NOTE_C,    dur: 4'd2};
      3'd1:    e = '{code: NOTE_E,    dur: 4'd2};
      3'd2:    e = '{code: NOTE_G,    dur: 4'd2};
      3'd3:    e = '{code: NOTE_REST, dur: 4'd1};
      3'd4:    e = '{code: NOTE_G,    dur: 4'd1};
      3'd5:    e = '{code: NOTE_E,    dur: 4'd1};
      3'd6:    e = '{code: NOTE_C,    dur: 4'd4};
      default: e = '{code: NOTE_REST, dur: 4'd2};
    endcase
    return e;
  endfunction

  // A zero duration would never expire, so it plays as one tick
  function automatic logic [3:0] eff_dur(input logic [3:0] d);
    return (d == 4'd0) ? 4'd1 : d;
  endfunction

endpackage

// File: rtl/note_sequencer_if.sv
// Control/status bundle of the note sequencer: start/stop/loop in, status pulses and tone out.
// Plain level/pulse signals; no handshake.
interface note_sequencer_if;
  logic       start;
  logic       stop;
  logic       loop;
  logic       busy;
  logic [2:0] note_index;
  logic       note_strobe;
  logic       done;
  logic       sound;

  modport master (
    output start, stop, loop,
    input  busy, note_index, note_strobe, done, sound
  );

  modport slave (
    input  start, stop, loop,
    output busy, note_index, note_strobe, done, sound
  );
endinterface

// File: rtl/note_sequencer_tone_divider.sv
// Square-wave generator: output flips every half_period enabled cycles; restart clears it to 0.
// Registered output, one cycle from restart/enable to sound.
module tone_divider (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        restart,
  input  logic        enable,
  input  logic [15:0] half_period,
  output logic        sound
);

  logic [15:0] cnt;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      cnt   <= '0;
      sound <= 1'b0;
    end else if (restart) begin
      cnt   <= '0;
      sound <= 1'b0;
    end else if (enable) begin
      if (cnt + 16'd1 >= half_period) begin
        cnt   <= '0;
        sound <= ~sound;
      end else begin
        cnt <= cnt + 16'd1;
      end
    end
  end

endmodule

// File: rtl/note_sequencer.sv
// Plays the fixed 8-entry melody: IDLE -> (LOAD -> PLAY) x8 -> IDLE, optional looping, stop aborts.
// Each entry lasts 1 + D*TICK_CYCLES cycles from its note_strobe; stop takes effect next cycle.
module note_sequencer
  import note_sequencer_pkg::*;
#(
  parameter int unsigned TICK_CYCLES   = DEF_TICK_CYCLES,
  parameter int unsigned HALF_PERIOD_C = DEF_HALF_C,
  parameter int unsigned HALF_PERIOD_E = DEF_HALF_E,
  parameter int unsigned HALF_PERIOD_G = DEF_HALF_G
) (
  input  logic             clock,
  input  logic             reset_n,
  note_sequencer_if.slave  bus
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_LOAD = 2'd1;
  localparam logic [1:0] ST_PLAY = 2'd2;

  localparam int TW = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;
  localparam logic [TW-1:0] TICK_LAST = TW'(TICK_CYCLES - 1);

  logic [1:0]    state, state_nxt;
  logic [2:0]    idx, idx_nxt;
  logic [TW-1:0] tick_cnt;
  logic [3:0]    ticks_left;
  logic [15:0]   half_period;
  logic          tone_en;
  logic          done_q;
  logic          finish;
  logic          tick_wrap;
  logic          last_tick;
  logic          div_restart;
  logic          sound_w;
  melody_entry_t entry;

  function automatic logic [15:0] half_of(input logic [1:0] code);
    case (code)
      NOTE_C:  return 16'(HALF_PERIOD_C);
      NOTE_E:  return 16'(HALF_PERIOD_E);
      NOTE_G:  return 16'(HALF_PERIOD_G);
      default: return 16'd0;
    endcase
  endfunction

  assign entry     = melody_entry(idx);
  assign tick_wrap = (tick_cnt == TICK_LAST);
  assign last_tick = tick_wrap && (ticks_left == 4'd1);

  always_comb begin
    state_nxt = state;
    idx_nxt   = idx;
    finish    = 1'b0;
    case (state)
      ST_IDLE: begin
        if (bus.start && !bus.stop) begin
          state_nxt = ST_LOAD;
          idx_nxt   = 3'd0;
        end
      end
      ST_LOAD: begin
        state_nxt = bus.stop ? ST_IDLE : ST_PLAY;
      end
      ST_PLAY: begin
        if (bus.stop) begin
          state_nxt = ST_IDLE;
        end else if (last_tick) begin
          if (idx != 3'd7) begin
            state_nxt = ST_LOAD;
            idx_nxt   = idx + 3'd1;
          end else if (bus.loop) begin
            state_nxt = ST_LOAD;
            idx_nxt   = 3'd0;
          end else begin
            state_nxt = ST_IDLE;
            finish    = 1'b1;
          end
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state       <= ST_IDLE;
      idx         <= 3'd0;
      tick_cnt    <= '0;
      ticks_left  <= 4'd0;
      half_period <= 16'd0;
      tone_en     <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state  <= state_nxt;
      idx    <= idx_nxt;
      done_q <= finish;
      if (state == ST_LOAD) begin
        tick_cnt    <= '0;
        ticks_left  <= eff_dur(entry.dur);
        half_period <= half_of(entry.code);
        tone_en     <= (entry.code != NOTE_REST);
      end else if (state == ST_PLAY) begin
        if (tick_wrap) begin
          tick_cnt   <= '0;
          ticks_left <= ticks_left - 4'd1;
        end else begin
          tick_cnt <= tick_cnt + 1'b1;
        end
      end else begin
        tick_cnt   <= '0;
        ticks_left <= 4'd0;
      end
    end
  end

  // Held in restart through LOAD (entry settings are still being latched) and whenever PLAY ends
  assign div_restart = (state == ST_LOAD) || (state_nxt != ST_PLAY);

  tone_divider u_tone (
    .clock       (clock),
    .reset_n     (reset_n),
    .restart     (div_restart),
    .enable      (tone_en),
    .half_period (half_period),
    .sound       (sound_w)
  );

  assign bus.busy        = (state != ST_IDLE);
  assign bus.note_index  = idx;
  assign bus.note_strobe = (state == ST_LOAD);
  assign bus.done        = done_q;
  assign bus.sound       = sound_w;

endmodule

// File: doc/note_sequencer.md
NOTE_SEQUENCER -- requirements
Module: note_sequencer

Interface
REQ-001 SHALL have parameter TICK_CYCLES, default 1200000, clock cycles per duration tick (100 ms at 12 MHz).
REQ-002 SHALL have parameters HALF_PERIOD_C, HALF_PERIOD_E, HALF_PERIOD_G, defaults 22933, 18202, 15306, tone half-periods in cycles for C1/E1/G1 at 12 MHz.
REQ-003 SHALL have port clock  in  1  system clock, 12 MHz.
REQ-004 SHALL have port reset_n  in  1  asynchronous active-low reset.
REQ-005 SHALL have port start  in  1  begin playback when idle.
REQ-006 SHALL have port stop  in  1  abort playback.
REQ-007 SHALL have port loop  in  1  restart at entry 0 after entry 7 instead of finishing.
REQ-008 SHALL have port busy  out  1  high in any non-IDLE state.
REQ-009 SHALL have port note_index  out  3  melody entry currently loaded or playing.
REQ-010 SHALL have port note_strobe  out  1  one-cycle pulse in each LOAD cycle.
REQ-011 SHALL have port done  out  1  one-cycle pulse on normal completion.
REQ-012 SHALL have port sound  out  1  square-wave tone output.

Function
REQ-013 SHALL hold a fixed 8-entry melody of {note code 2b: 0 rest, 1 C, 2 E, 3 G; duration 4b in ticks}: (C,2)(E,2)(G,2)(rest,1)(G,1)(E,1)(C,4)(rest,2).
REQ-014 SHALL implement states IDLE, LOAD, PLAY.
REQ-015 SHALL move IDLE->LOAD on start=1 with stop=0, setting note_index=0.
REQ-016 SHALL, in LOAD (exactly one cycle), select the entry's half-period, restart the tone divider with sound=0, clear the tick counter and load remaining ticks, then enter PLAY.
REQ-017 SHALL treat a duration field of 0 as 1.
REQ-018 SHALL, in PLAY, count cycles modulo TICK_CYCLES and decrement remaining ticks at each wrap; on the wrap that ends the last tick, leave PLAY.
REQ-019 SHALL make every entry occupy exactly 1 + D*TICK_CYCLES cycles, counted from its note_strobe.
REQ-020 SHALL, leaving PLAY with note_index<7, go to LOAD with note_index+1.
REQ-021 SHALL, leaving PLAY with note_index=7, go to LOAD with note_index 0 if loop=1 (sampled that cycle); otherwise go to IDLE and pulse done in the first IDLE cycle.
REQ-022 SHALL toggle sound every half-period cycles while PLAY holds a C/E/G entry; SHALL hold sound at 0 in IDLE, LOAD and rest entries.
REQ-023 SHALL ignore start while busy=1.
REQ-024 SHALL return to IDLE on the cycle after stop=1 from any state, with sound=0, without pulsing done.
REQ-025 SHALL give stop priority over start when both are high in the same cycle.

Reset
REQ-026 SHALL, on reset_n=0, immediately force state IDLE, note_index=0, busy=0, note_strobe=0, done=0, sound=0, and clear all counters.
REQ-027 SHALL, after reset_n deasserts mid-playback, remain in IDLE until a new start.

Structure
REQ-028 SHALL take note-code encodings and default half-period constants from a shared note-constants include file, reused by other sound exercises.
REQ-029 SHALL instantiate one sub-module, tone_divider (16-bit programmable half-period counter with synchronous restart and enable), producing sound.
REQ-030 SHALL keep the melody table, FSM and tick/duration counters in note_sequencer.

Verification
REQ-031 SHALL verify reset values: assert reset_n=0 mid-note -> all outputs 0 within the same cycle; after release, busy stays 0 with no start.
REQ-032 SHALL verify a full play: TICK_CYCLES=4, half-periods 3/5/7, one start pulse -> note_strobe at offsets 0,9,18,27,32,37,42,59 from first strobe; done exactly 68 cycles after first strobe; busy=0 that cycle.
REQ-033 SHALL verify tone shape: during entry 0, sound 0 in LOAD, then toggles every 3 cycles; during entry 3 (rest), sound constant 0.
REQ-034 SHALL verify loop: loop=1 -> no done pulse; note_index 7->0 with note_strobe 68 cycles after first strobe; second pass timing identical.
REQ-035 SHALL verify stop: stop=1 at 3rd PLAY cycle of entry 2 -> next cycle IDLE, sound=0, busy=0, no done; start then replays from entry 0.
REQ-036 SHALL verify priorities: start while busy -> no restart, note_index unchanged; start and stop together in IDLE -> remains IDLE.
